// File: rtl/bitwise_lu_seq.sv
// Multi-cycle bitwise logic unit: processes CHUNK bits of a/b per cycle over WIDTH/CHUNK RUN cycles.
// Optional result-is-zero flag enabled by defining BITWISE_LU_ZERO_FLAG_EN.
module bitwise_lu_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 0) ? $clog2(N + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;

  if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
    $error("bitwise_lu_seq: WIDTH must be a positive multiple of CHUNK");
  end

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [31:0]      off;
  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] r_sl;
  logic [WIDTH-1:0] next_result;
  logic             accept;
  logic             last;

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Current slice of the latched operands and the result with that slice replaced.
  always_comb begin
    off  = 32'(cnt) * 32'(CHUNK);
    a_sl = a_q[off +: CHUNK];
    b_sl = b_q[off +: CHUNK];
    case (op_q)
      OP_AND:  r_sl = a_sl & b_sl;
      OP_OR:   r_sl = a_sl | b_sl;
      OP_XOR:  r_sl = a_sl ^ b_sl;
      default: r_sl = ~(a_sl | b_sl);
    endcase
    next_result = result;
    next_result[off +: CHUNK] = r_sl;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_AND;
      result <= '0;
    end else begin
      case (state)
        RUN: begin
          result <= next_result;
          if (last) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; DONE otherwise falls back to IDLE.
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= op;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef BITWISE_LU_ZERO_FLAG_EN
  logic zero_q;

  // Flag captured from the completed result on entry to DONE, cleared by the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b0;
    end else if (state == RUN && last) begin
      zero_q <= (next_result == '0);
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_lu_seq.sv
// Directed bench for bitwise_lu_seq: main checks on a CHUNK=8 instance, plus CHUNK 1/4/32 sweep.
module tb_bitwise_lu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;

  logic        busy8, done8, zero8;
  logic [31:0] result8;
  logic        busy4, done4, zero4;
  logic [31:0] result4;
  logic        busy1, done1, zero1;
  logic [31:0] result1;
  logic        busy32, done32, zero32;
  logic [31:0] result32;

  int checks = 0;
  int errors = 0;

  bitwise_lu_seq #(.WIDTH(32), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy8), .done(done8), .result(result8), .zero(zero8));
  bitwise_lu_seq #(.WIDTH(32), .CHUNK(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy4), .done(done4), .result(result4), .zero(zero4));
  bitwise_lu_seq #(.WIDTH(32), .CHUNK(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .result(result1), .zero(zero1));
  bitwise_lu_seq #(.WIDTH(32), .CHUNK(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy32), .done(done32), .result(result32), .zero(zero32));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] refOp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  function automatic logic expZero(input logic [31:0] r);
`ifdef BITWISE_LU_ZERO_FLAG_EN
    return (r == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Pulse start for one edge; returns 1ns after the accepting edge.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk);
    #1;
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges after acceptance until done8; c=1 is the first RUN cycle.
  task automatic waitDone(input string tag, output int cycles);
    cycles = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput({tag, "_busy1"}, 32'(busy8), 32'd1);
        checkOutput({tag, "_zeroclr"}, 32'(zero8), 32'd0);
      end
      if (done8) begin
        cycles = c;
        break;
      end
    end
  endtask

  task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] expected);
    int cyc;
    applyStimulus(o, x, y);
    waitDone(tag, cyc);
    checkOutput({tag, "_lat"}, 32'(cyc), 32'd5);
    checkOutput({tag, "_res"}, result8, expected);
    checkOutput({tag, "_zero"}, 32'(zero8), 32'(expZero(expected)));
    @(negedge clk);
    checkOutput({tag, "_idle"}, {30'd0, busy8, done8}, 32'd0);
    checkOutput({tag, "_hold"}, result8, expected);
  endtask

  initial begin
    int cyc;
    int ndone;
    int at8, at4, at1, at32;
    logic [31:0] x, y, e;
    logic [1:0]  o;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_result", result8, 32'd0);
    checkOutput("rst_zero", 32'(zero8), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    runAndCheck("xor", 2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB);
    runAndCheck("and0", 2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0000_0000);
    runAndCheck("or", 2'b01, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678);
    runAndCheck("nor", 2'b11, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);

    // Back-to-back: NOR of zeros, then a new start issued during the done cycle
    applyStimulus(2'b11, 32'h0, 32'h0);
    waitDone("b2b1", cyc);
    checkOutput("b2b1_lat", 32'(cyc), 32'd5);
    checkOutput("b2b1_res", result8, 32'hFFFF_FFFF);
    start = 1'b1;
    op = 2'b01;
    a = 32'h1;
    b = 32'h2;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("b2b2", cyc);
    checkOutput("b2b2_lat", 32'(cyc), 32'd5);
    checkOutput("b2b2_res", result8, 32'h0000_0003);
    @(negedge clk);

    // start held high while a/b change every RUN cycle
    @(posedge clk);
    #1;
    start = 1'b1;
    op = 2'b10;
    a = 32'h1357_9BDF;
    b = 32'h0F0F_0F0F;
    ndone = 0;
    cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      @(negedge clk);
      if (done8) begin
        ndone++;
        cyc = c;
        checkOutput("hold_res", result8, 32'h1C58_94D0);
        start = 1'b0;
        break;
      end
    end
    checkOutput("hold_lat", 32'(cyc), 32'd5);
    @(negedge clk);
    if (done8) ndone++;
    checkOutput("hold_ndone", 32'(ndone), 32'd1);

    // Reset in the second RUN cycle
    applyStimulus(2'b01, 32'hFFFF_0000, 32'h0000_FFFF);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_result", result8, 32'd0);
    checkOutput("abort_zero", 32'(zero8), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    checkOutput("abort_nodone", 32'(ndone), 32'd0);
    runAndCheck("after", 2'b00, 32'hDEAD_BEEF, 32'h0FF0_F00F, 32'h0EA0_B00F);

    // Parameter sweep across CHUNK 8/4/1/32 against the reference model
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i);
      x = $urandom;
      y = $urandom;
      e = refOp(o, x, y);
      applyStimulus(o, x, y);
      at8 = 0; at4 = 0; at1 = 0; at32 = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (done8 && at8 == 0) at8 = c;
        if (done4 && at4 == 0) at4 = c;
        if (done1 && at1 == 0) at1 = c;
        if (done32 && at32 == 0) at32 = c;
      end
      checkOutput($sformatf("sw%0d_lat8", i), 32'(at8), 32'd5);
      checkOutput($sformatf("sw%0d_lat4", i), 32'(at4), 32'd9);
      checkOutput($sformatf("sw%0d_lat1", i), 32'(at1), 32'd33);
      checkOutput($sformatf("sw%0d_lat32", i), 32'(at32), 32'd2);
      checkOutput($sformatf("sw%0d_res8", i), result8, e);
      checkOutput($sformatf("sw%0d_res4", i), result4, e);
      checkOutput($sformatf("sw%0d_res1", i), result1, e);
      checkOutput($sformatf("sw%0d_res32", i), result32, e);
      checkOutput($sformatf("sw%0d_zero32", i), 32'(zero32), 32'(expZero(e)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitwise_lu_seq.md
BITWISE_LU_SEQ -- requirements
Module: bitwise_lu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 8, bits processed per cycle.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock.
REQ-005 The block SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 The block SHALL have port start  input  1  request a new operation.
REQ-007 The block SHALL have port op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 The block SHALL have port a  input  WIDTH  first operand.
REQ-009 The block SHALL have port b  input  WIDTH  second operand.
REQ-010 The block SHALL have port busy  output  1  operation in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 The block SHALL have port result  output  WIDTH  bitwise result, held until the next accepted start.
REQ-013 The block SHALL have port zero  output  1  result-equals-zero flag.

Function
REQ-014 WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK chunk cycles per operation.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at a clock edge SHALL latch a, b and op, clear the chunk counter to 0, and enter RUN.
REQ-017 In RUN, start SHALL be ignored; latched operands SHALL be unaffected by changes on a, b and op.
REQ-018 Each RUN cycle SHALL write result[k*CHUNK +: CHUNK] = op(latched a slice, latched b slice) for counter value k, then increment k.
REQ-019 When the slice with k = N-1 is written, the FSM SHALL go to DONE.
REQ-020 DONE SHALL last exactly one cycle; without start, the FSM SHALL then enter IDLE.
REQ-021 busy SHALL be 1 exactly while in RUN; done SHALL be 1 exactly while in DONE.
REQ-022 Latency SHALL be fixed: start sampled at edge 0 gives done=1 during the cycle after edge N; a new start is accepted in that same cycle.
REQ-023 result SHALL show partial (mixed old/new) slices while busy=1; it is valid only when done=1 and thereafter until the next accepted start.
REQ-024 For N = 1 (CHUNK = WIDTH), operation SHALL complete in one RUN cycle with the same protocol.
REQ-025 The chunk counter SHALL be ceil(log2(N+1)) bits wide and SHALL never exceed N-1 in RUN.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, counter 0, result 0, busy 0, done 0 and zero 0, independent of clk.
REQ-027 Reset during RUN SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-028 With macro BITWISE_LU_ZERO_FLAG_EN defined, zero SHALL be registered on entry to DONE as (final result == 0) and held until the next accepted start, when it is cleared to 0.
REQ-029 Without BITWISE_LU_ZERO_FLAG_EN, zero SHALL be tied to 0 and no zero-detect logic SHALL be synthesised; all other behaviour is identical.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-030 a=0xF0F0_1234, b=0x0FF0_FFFF, op=10, start pulsed -> busy for 4 cycles, then done=1 for one cycle with result=0xFF00_EDCB; with the flag macro, zero=0.
REQ-031 a=0xAAAA_AAAA, b=0x5555_5555, op=00 -> result=0x0000_0000 at done; zero=1 with the macro, zero=0 without it.
REQ-032 op=11, a=b=0x0000_0000 -> result=0xFFFF_FFFF; then a new start with op=01, a=0x1, b=0x2 is issued in the done cycle -> busy the next cycle, result=0x0000_0003 four cycles later, with no IDLE gap.
REQ-033 start held high, with a and b changed every cycle during RUN -> result is computed from the operands latched at acceptance only; exactly one done per operation.
REQ-034 rst asserted in the second RUN cycle -> busy, done, result and zero are 0 immediately; no done pulse; a later operation completes correctly.
REQ-035 Parameter sweep CHUNK in {1, 4, 32} against a bitwise reference model with random operands and all four ops -> done arrives exactly N cycles after start, and result matches the model.
